fm_multibuf_window: RTL and testbench

- Parametrised N-way feature-map buffer with a streaming write side and a sliding-window read side.
- Bytes stream in with a valid/ready handshake and fill buffers round-robin; a full buffer is committed.
- Each committed buffer is read out as WINDOW-element windows at a configurable STRIDE, then released for reuse.
- Sits between the feature-map producer and the MinHash/projection datapath.

---
 rtl/fm_multibuf_window.sv | 142 ++++++++++++++
 tb/tb_fm_multibuf_window.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_multibuf_window.sv
// N-way feature-map buffer: round-robin streaming writes, sliding-window reads at STRIDE.
// Optional `FM_ABORT_EN adds in_abort to discard a partially written buffer.
module fm_multibuf_window #(
  parameter int BUFFER_COUNT = 2,
  parameter int BUFFER_SIZE  = 64,
  parameter int DATA_BITS    = 8,
  parameter int WINDOW       = 2,
  parameter int STRIDE       = 2,
  localparam int IDX_W = $clog2(BUFFER_COUNT > 2 ? BUFFER_COUNT : 2),
  localparam int OCC_W = $clog2(BUFFER_COUNT + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef FM_ABORT_EN
  input  logic                        in_abort,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_BITS-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WINDOW*DATA_BITS-1:0] out_data,
  output logic                        out_last,
  output logic [IDX_W-1:0]            out_buf_idx,
  output logic [OCC_W-1:0]            occupancy
);

  localparam int PTR_W      = $clog2(BUFFER_SIZE > 1 ? BUFFER_SIZE : 2);
  localparam int NWIN       = (BUFFER_SIZE - WINDOW) / STRIDE + 1;
  localparam int LAST_START = (NWIN - 1) * STRIDE;

  logic [DATA_BITS-1:0] mem [BUFFER_COUNT][BUFFER_SIZE];

  logic [IDX_W-1:0]            wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic                        out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [WINDOW*DATA_BITS-1:0] out_data_q, out_data_d, win;
  logic [IDX_W-1:0]            out_idx_q, out_idx_d;
  logic                        abort, accept, commit, release_buf, is_last, load_en;

`ifdef FM_ABORT_EN
  assign abort = in_abort;
`else
  assign abort = 1'b0;
`endif

  assign in_ready = (occ_q < OCC_W'(BUFFER_COUNT));
  assign accept   = in_valid & in_ready & ~abort;
  assign commit   = accept && (wr_ptr_q == PTR_W'(BUFFER_SIZE - 1));
  assign is_last  = (rd_ptr_q == PTR_W'(LAST_START));
  assign load_en  = ~out_valid_q | out_ready;
  assign release_buf = load_en && (occ_q != '0) && is_last;

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < WINDOW; i++)
      win[i*DATA_BITS +: DATA_BITS] = mem[rd_buf_q][rd_ptr_q + PTR_W'(i)];
  end

  always_comb begin
    wr_buf_d    = wr_buf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_buf_d    = rd_buf_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;

    if (abort) begin
      wr_ptr_d = '0;
    end else if (accept) begin
      if (commit) begin
        wr_ptr_d = '0;
        wr_buf_d = (wr_buf_q == IDX_W'(BUFFER_COUNT - 1)) ? '0 : wr_buf_q + IDX_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end

    if (load_en) begin
      if (occ_q != '0) begin
        out_valid_d = 1'b1;
        out_data_d  = win;
        out_idx_d   = rd_buf_q;
        out_last_d  = is_last;
        if (is_last) begin
          rd_ptr_d = '0;
          rd_buf_d = (rd_buf_q == IDX_W'(BUFFER_COUNT - 1)) ? '0 : rd_buf_q + IDX_W'(1);
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_W'(STRIDE);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // Commit and release in the same cycle cancel out.
    case ({commit, release_buf})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_buf_q][wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_buf_q    <= '0;
      wr_ptr_q    <= '0;
      rd_buf_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      wr_buf_q    <= wr_buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_buf_q    <= rd_buf_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_buf_idx = out_idx_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_fm_multibuf_window.sv
// Directed bench for fm_multibuf_window: two instances (stride-2 pairs, stride-1 triples).
module tb_fm_multibuf_window;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: BUFFER_COUNT=2, BUFFER_SIZE=8, WINDOW=2, STRIDE=2
  logic a_vld = 1'b0, a_irdy, a_ovld, a_ordy = 1'b0, a_last;
  logic [7:0]  a_din = '0;
  logic [15:0] a_dout;
  logic        a_idx;
  logic [1:0]  a_occ;
`ifdef FM_ABORT_EN
  logic a_abort = 1'b0;
`endif

  // Instance B: BUFFER_COUNT=2, BUFFER_SIZE=8, WINDOW=3, STRIDE=1
  logic b_vld = 1'b0, b_irdy, b_ovld, b_ordy = 1'b0, b_last;
  logic [7:0]  b_din = '0;
  logic [23:0] b_dout;
  logic        b_idx;
  logic [1:0]  b_occ;

  fm_multibuf_window #(.BUFFER_COUNT(2), .BUFFER_SIZE(8), .DATA_BITS(8), .WINDOW(2), .STRIDE(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef FM_ABORT_EN
    .in_abort(a_abort),
`endif
    .in_valid(a_vld), .in_ready(a_irdy), .in_data(a_din),
    .out_valid(a_ovld), .out_ready(a_ordy), .out_data(a_dout),
    .out_last(a_last), .out_buf_idx(a_idx), .occupancy(a_occ));

  fm_multibuf_window #(.BUFFER_COUNT(2), .BUFFER_SIZE(8), .DATA_BITS(8), .WINDOW(3), .STRIDE(1)) dut_b (
`ifdef FM_ABORT_EN
    .in_abort(1'b0),
`endif
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_vld), .in_ready(b_irdy), .in_data(b_din),
    .out_valid(b_ovld), .out_ready(b_ordy), .out_data(b_dout),
    .out_last(b_last), .out_buf_idx(b_idx), .occupancy(b_occ));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_vld = 1'b0; a_ordy = 1'b0; a_din = '0;
    b_vld = 1'b0; b_ordy = 1'b0; b_din = '0;
`ifdef FM_ABORT_EN
    a_abort = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        vld;
    logic [7:0]  din;
    logic        ordy;
    logic        e_irdy;
    logic        e_vld;
    logic [15:0] e_data;
    logic        e_last;
    logic        e_idx;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic ir, logic ov,
                              logic [15:0] od, logic ol, logic oi, logic [1:0] oc);
    vec_t t;
    t.vld = v; t.din = d; t.ordy = r; t.e_irdy = ir; t.e_vld = ov;
    t.e_data = od; t.e_last = ol; t.e_idx = oi; t.e_occ = oc;
    return t;
  endfunction

  // Each record: inputs for one edge, expected outputs just after that edge.
  task automatic run_basic(input string tag);
    for (int k = 0; k < 13; k++) begin
      a_vld = tbl[k].vld; a_din = tbl[k].din; a_ordy = tbl[k].ordy;
      step();
      chk($sformatf("%s[%0d].in_ready", tag, k), 32'(a_irdy), 32'(tbl[k].e_irdy));
      chk($sformatf("%s[%0d].out_valid", tag, k), 32'(a_ovld), 32'(tbl[k].e_vld));
      chk($sformatf("%s[%0d].out_data", tag, k), 32'(a_dout), 32'(tbl[k].e_data));
      chk($sformatf("%s[%0d].occupancy", tag, k), 32'(a_occ), 32'(tbl[k].e_occ));
      if (tbl[k].e_vld) begin
        chk($sformatf("%s[%0d].out_last", tag, k), 32'(a_last), 32'(tbl[k].e_last));
        chk($sformatf("%s[%0d].out_buf_idx", tag, k), 32'(a_idx), 32'(tbl[k].e_idx));
      end
    end
    a_vld = 1'b0;
  endtask

  initial begin
    logic [15:0] got[16];
    logic        gidx[16];
    int n, acc, gaps, maxocc;

    for (int k = 0; k < 7; k++) tbl[k] = mk(1'b1, 8'(k), 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0);
    tbl[7]  = mk(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd1);
    tbl[8]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 2'd1);
    tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0302, 1'b0, 1'b0, 2'd1);
    tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0504, 1'b0, 1'b0, 2'd1);
    tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0706, 1'b1, 1'b0, 2'd0);
    tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0706, 1'b0, 1'b0, 2'd0);

    // Reset state
    do_reset();
    chk("rst.out_valid", 32'(a_ovld), 32'd0);
    chk("rst.occupancy", 32'(a_occ), 32'd0);
    chk("rst.in_ready", 32'(a_irdy), 32'd1);
    chk("rst.out_data", 32'(a_dout), 32'd0);

    run_basic("basic");

    // Overlapping windows, WINDOW=3 STRIDE=1
    do_reset();
    b_ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_vld = 1'b1; b_din = 8'(8'h10 + k);
      step();
    end
    b_vld = 1'b0;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      if (b_ovld) begin
        if (n < 6) begin
          chk($sformatf("ovl[%0d].data", n), 32'(b_dout),
              32'({8'(8'h12 + n), 8'(8'h11 + n), 8'(8'h10 + n)}));
          chk($sformatf("ovl[%0d].last", n), 32'(b_last), 32'(n == 5));
          chk($sformatf("ovl[%0d].idx", n), 32'(b_idx), 32'd0);
        end
        n++;
      end
      step();
    end
    chk("ovl.count", 32'(n), 32'd6);
    chk("ovl.occupancy", 32'(b_occ), 32'd0);
    chk("ovl.in_ready", 32'(b_irdy), 32'd1);

    // Backpressure until both buffers are full
    do_reset();
    a_ordy = 1'b0; a_vld = 1'b1; acc = 0;
    for (int c = 0; c < 30; c++) begin
      a_din = 8'(acc);
      if (a_irdy) acc++;
      step();
    end
    a_vld = 1'b0;
    chk("bp.accepts", 32'(acc), 32'd16);
    chk("bp.in_ready", 32'(a_irdy), 32'd0);
    chk("bp.occupancy", 32'(a_occ), 32'd2);
    chk("bp.out_valid", 32'(a_ovld), 32'd1);
    chk("bp.held_data", 32'(a_dout), 32'h0100);
    a_ordy = 1'b1; n = 0;
    for (int c = 0; c < 20 && n < 8; c++) begin
      if (a_ovld) begin got[n] = a_dout; gidx[n] = a_idx; n++; end
      step();
    end
    chk("bp.count", 32'(n), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bp[%0d].data", k), 32'(got[k]), 32'({8'(2*k + 1), 8'(2*k)}));
      chk($sformatf("bp[%0d].idx", k), 32'(gidx[k]), 32'(k / 4));
    end
    step();
    chk("bp.in_ready_back", 32'(a_irdy), 32'd1);
    chk("bp.occupancy_end", 32'(a_occ), 32'd0);

    // Ping-pong: three buffers back to back
    do_reset();
    a_ordy = 1'b1; acc = 0; gaps = 0; maxocc = 0; n = 0;
    for (int c = 0; c < 60 && n < 12; c++) begin
      a_vld = (acc < 24);
      a_din = 8'(acc);
      if (a_vld && !a_irdy) gaps++;
      if (a_vld && a_irdy) acc++;
      if (int'(a_occ) > maxocc) maxocc = int'(a_occ);
      if (a_ovld) begin got[n] = a_dout; gidx[n] = a_idx; n++; end
      step();
    end
    a_vld = 1'b0;
    chk("pp.accepts", 32'(acc), 32'd24);
    chk("pp.ready_gaps", 32'(gaps), 32'd0);
    chk("pp.max_occupancy", 32'(maxocc), 32'd1);
    chk("pp.count", 32'(n), 32'd12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("pp[%0d].idx", k), 32'(gidx[k]), 32'((k / 4) % 2));
      chk($sformatf("pp[%0d].data", k), 32'(got[k]), 32'({8'(2*k + 1), 8'(2*k)}));
    end

    // Reset with one committed buffer, a partial buffer and a window held
    do_reset();
    a_ordy = 1'b0;
    for (int k = 0; k < 13; k++) begin
      a_vld = 1'b1; a_din = 8'(8'h40 + k);
      step();
    end
    a_vld = 1'b0;
    chk("mid.pre_valid", 32'(a_ovld), 32'd1);
    chk("mid.pre_data", 32'(a_dout), 32'h4140);
    rst_n = 1'b0;
    step();
    chk("mid.out_valid", 32'(a_ovld), 32'd0);
    chk("mid.occupancy", 32'(a_occ), 32'd0);
    chk("mid.out_data", 32'(a_dout), 32'd0);
    rst_n = 1'b1;
    run_basic("after_rst");

`ifdef FM_ABORT_EN
    do_reset();
    a_ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_vld = 1'b1; a_din = 8'(8'h90 + k);
      step();
    end
    a_abort = 1'b1; a_din = 8'hEE;
    step();
    a_abort = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a_din = 8'(8'h20 + k);
      step();
    end
    a_vld = 1'b0; n = 0;
    for (int c = 0; c < 15; c++) begin
      if (a_ovld) begin if (n < 16) got[n] = a_dout; n++; end
      step();
    end
    chk("abort.count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("abort[%0d].data", k), 32'(got[k]),
          32'({8'(8'h21 + 2*k), 8'(8'h20 + 2*k)}));
    chk("abort.occupancy", 32'(a_occ), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
